ras_param: RTL and testbench

//  Parametrised return address stack for the fetch predictors; generalises the fixed 8-entry RAS.

---
 rtl/ras_param.sv | 122 ++++++++++++
 tb/tb_ras_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ras_param.sv
`default_nettype none
// ============================================================================
// Module      : ras_param
// Description : Parametrised return address stack for the fetch predictors.
//               Circular storage: a push at full overwrites the oldest entry.
//               The top pointer is exported so fetch can checkpoint it and
//               restore speculative state in a single cycle.
//               Optional macro RAS_PARAM_COUNT_EN enables the occupancy
//               counter (ras_count / ras_empty). When it is not defined,
//               ras_count and ras_empty are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_param #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_target,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_ras_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_ras_count
);

    localparam logic [RAS_INDEX_WIDTH-1:0] c_idx_one = RAS_INDEX_WIDTH'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_q;
    logic [RAS_INDEX_WIDTH-1:0]  index_d;
    logic [RAS_INDEX_WIDTH-1:0]  index_inc;

    assign index_inc  = index_q + c_idx_one;
    assign ret_target = stack_q[index_q];
    assign ras_index  = index_q;

    // Next pointer and entry contents; restore wins and never touches entries.
    always_comb begin
        stack_d = stack_q;
        index_d = index_q;
        if (restore_valid) begin
            index_d = restore_ras_index;
        end else if (link_valid && ret_valid) begin
            // Coroutine swap: replace the top in place, pointer unchanged.
            stack_d[index_q] = link_target;
        end else if (link_valid) begin
            index_d            = index_inc;
            stack_d[index_inc] = link_target;
        end else if (ret_valid) begin
            index_d = index_q - c_idx_one;
        end
    end

    // Stack storage and top pointer registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
            index_q <= '0;
        end else begin
            stack_q <= stack_d;
            index_q <= index_d;
        end
    end

`ifdef RAS_PARAM_COUNT_EN
    localparam logic [RAS_INDEX_WIDTH:0] c_cnt_one  = (RAS_INDEX_WIDTH+1)'(1);
    localparam logic [RAS_INDEX_WIDTH:0] c_cnt_full = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

    logic [RAS_INDEX_WIDTH:0] count_q;
    logic [RAS_INDEX_WIDTH:0] count_d;

    // Occupancy: saturates at full on push, floors at zero on pop.
    always_comb begin
        count_d = count_q;
        if (restore_valid) begin
            count_d = restore_ras_count;
        end else if (link_valid && ret_valid) begin
            if (count_q == '0) begin
                count_d = c_cnt_one;
            end
        end else if (link_valid) begin
            if (count_q != c_cnt_full) begin
                count_d = count_q + c_cnt_one;
            end
        end else if (ret_valid) begin
            if (count_q != '0) begin
                count_d = count_q - c_cnt_one;
            end
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ras_count = count_q;
    assign ras_empty = (count_q == '0);
`else
    // Without the counter the restore count has no destination.
    logic unused_restore_count;
    assign unused_restore_count = ^restore_ras_count;

    assign ras_count = '0;
    assign ras_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ras_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_param
// Description : Scoreboard testbench for ras_param. A reference model updates
//               on every driven cycle and queues the expected post-edge state,
//               which is popped and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_param;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 31;

`ifdef RAS_PARAM_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          nRST;
    logic          link_valid;
    logic [TW-1:0] link_target;
    logic          ret_valid;
    logic [TW-1:0] ret_target;
    logic [IW-1:0] ras_index;
    logic [IW:0]   ras_count;
    logic          ras_empty;
    logic          restore_valid;
    logic [IW-1:0] restore_ras_index;
    logic [IW:0]   restore_ras_count;

    ras_param #(
        .RAS_ENTRIES      (N),
        .RAS_INDEX_WIDTH  (IW),
        .RAS_TARGET_WIDTH (TW)
    ) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .link_valid        (link_valid),
        .link_target       (link_target),
        .ret_valid         (ret_valid),
        .ret_target        (ret_target),
        .ras_index         (ras_index),
        .ras_count         (ras_count),
        .ras_empty         (ras_empty),
        .restore_valid     (restore_valid),
        .restore_ras_index (restore_ras_index),
        .restore_ras_count (restore_ras_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [IW:0]   cnt;
        logic          empty;
        logic [TW-1:0] top;
    } exp_t;

    exp_t          r_q[$];
    logic [TW-1:0] m_stack [N];
    int            m_idx;
    int            m_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check the zero-latency prediction,
    // advance the model, queue the expected state, compare after posedge.
    task automatic cyc(input bit rst_n, input bit lv, input logic [TW-1:0] lt, input bit rv,
                       input bit rs, input int ri, input int rc);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        nRST              = rst_n;
        link_valid        = lv;
        link_target       = lt;
        ret_valid         = rv;
        restore_valid     = rs;
        restore_ras_index = IW'(ri);
        restore_ras_count = (IW+1)'(rc);
        #1;
        if (rst_n) chk("ret_now", 32'(ret_target), 32'(m_stack[m_idx]));
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_stack[i] = '0;
            m_idx = 0;
            m_cnt = 0;
        end else if (rs) begin
            m_idx = ri;
            m_cnt = rc;
        end else if (lv && rv) begin
            m_stack[m_idx] = lt;
            if (m_cnt == 0) m_cnt = 1;
        end else if (lv) begin
            m_idx = (m_idx + 1) % N;
            m_stack[m_idx] = lt;
            if (m_cnt < N) m_cnt = m_cnt + 1;
        end else if (rv) begin
            m_idx = (m_idx + N - 1) % N;
            if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
        e.idx   = IW'(m_idx);
        e.cnt   = CNT_EN ? (IW+1)'(m_cnt) : '0;
        e.empty = CNT_EN ? (m_cnt == 0) : 1'b0;
        e.top   = m_stack[m_idx];
        r_q.push_back(e);
        @(posedge CLK);
        #1;
        g = r_q.pop_front();
        chk("index", 32'(ras_index), 32'(g.idx));
        chk("count", 32'(ras_count), 32'(g.cnt));
        chk("empty", 32'(ras_empty), 32'(g.empty));
        chk("top",   32'(ret_target), 32'(g.top));
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic push(input logic [TW-1:0] t);
        cyc(1'b1, 1'b1, t, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_stack[i] = '0;
        m_idx = 0;
        m_cnt = 0;
        nRST = 1'b0; link_valid = 1'b0; link_target = '0; ret_valid = 1'b0;
        restore_valid = 1'b0; restore_ras_index = '0; restore_ras_count = '0;

        // Reset state with no stimulus.
        do_reset();
        idle();

        // Three pushes then three pops, LIFO order.
        push(31'h100); push(31'h200); push(31'h300);
        pop(); pop(); pop();

        // Overflow past depth: oldest entries overwritten, count saturates.
        do_reset();
        for (int v = 'h10; v <= 'h19; v++) push(TW'(v));
        for (int k = 0; k < 8; k++) pop();

        // Push then same-cycle push+pop swap.
        do_reset();
        push(31'hA);
        cyc(1'b1, 1'b1, 31'hB, 1'b1, 1'b0, 0, 0);
        idle();

        // Checkpoint at idx 2/cnt 2, push twice, restore with a colliding push.
        do_reset();
        push(31'h1); push(31'h2);
        push(31'hC); push(31'hD);
        cyc(1'b1, 1'b1, 31'hE, 1'b0, 1'b1, 2, 2);
        idle();

        // Pop at empty wraps index, count floors at zero.
        do_reset();
        pop();
        pop();

        // Swap at empty bumps the count to one.
        do_reset();
        cyc(1'b1, 1'b1, 31'h55, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of traffic discards the same-cycle push.
        push(31'h77);
        cyc(1'b0, 1'b1, 31'h99, 1'b0, 1'b0, 0, 0);
        idle();

        // Randomised traffic against the model.
        for (int k = 0; k < 200; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      push(TW'($urandom));
            else if (sel < 7) pop();
            else if (sel < 8) cyc(1'b1, 1'b1, TW'($urandom), 1'b1, 1'b0, 0, 0);
            else if (sel < 9) cyc(1'b1, 1'($urandom), TW'($urandom), 1'($urandom), 1'b1,
                                  int'($urandom_range(0, N-1)), int'($urandom_range(0, N)));
            else              idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
